sdram_req_arbiter: RTL
======================

// Module: sdram_req_arbiter
// PURPOSE
// Client-side initiator for the SDRAM controller's req/ack interface: watches the write-FIFO and read-FIFO fill levels.
// Raises sdram_wr_req / sdram_rd_req with a fixed burst length and supplies the matching burst start address.
// Advances and wraps frame addresses after each burst. Sits between the LCD/flash FIFOs and the SDRAM controller.
// Never has more than one request outstanding.
// PARAMETERS
// BURST       9'd256    words per burst, 1..256; driven on sdwr_byte/sdrd_byte
// ADDR_W      22        SDRAM word-address width {bank,row,col}
// FRAME_WORDS 22'd384000 words per frame buffer; address wraps to 0 at this count; must be a multiple of BURST
// WR_THRESH   9'd256    write burst allowed when wrfifo_usedw >= WR_THRESH
// RD_THRESH   9'd256    read burst allowed when rdfifo_usedw < RD_THRESH (room for BURST words)
// PORTS
// clk             in   1        system clock, 100 MHz, same domain as SDRAM controller
// rst_n           in   1        asynchronous active-low reset
// sdram_init_done in   1        controller initialisation complete
// rd_enable       in   1        display path wants read data (level)
// wrfifo_usedw    in   9        write-FIFO words available
// rdfifo_usedw    in   9        read-FIFO words occupied
// sdram_wr_ack    in   1        controller write ack; high for the burst (also write-FIFO rdreq)
// sdram_rd_ack    in   1        controller read ack; high for the burst (also read-FIFO wrreq)
// sdram_wr_req    out  1        write request to controller
// sdram_rd_req    out  1        read request to controller
// sdwr_byte       out  9        write burst length, constant BURST
// sdrd_byte       out  9        read burst length, constant BURST
// sys_wraddr      out  ADDR_W   start address of current/next write burst
// sys_rdaddr      out  ADDR_W   start address of current/next read burst
// wr_frame_done   out  1        1-cycle pulse when the write address wraps
// rd_frame_done   out  1        1-cycle pulse when the read address wraps
// BEHAVIOUR
// Reset: state IDLE. All outputs 0 except sdwr_byte/sdrd_byte = BURST. ack_d registers = 0. last_grant = RD, so writes win first.
// FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY. All outputs are registered.
// IDLE: no action while sdram_init_done=0.
//  wr_ok = wrfifo_usedw >= WR_THRESH.
//  rd_ok = rd_enable & rdfifo_usedw < RD_THRESH.
//  Both ok: grant the opposite of last_grant (round-robin). One ok: grant it. Neither: stay.
//  Grant WR: sdram_wr_req<=1, go WR_REQ. Grant RD: sdram_rd_req<=1, go RD_REQ.
//  last_grant updates on each grant.
// WR_REQ: hold req until the sdram_wr_ack rising edge (ack & ~ack_d). Then req<=0, go WR_BUSY.
//  No timeout; refresh may delay the ack an arbitrary number of cycles.
// WR_BUSY: on the ack falling edge (~ack & ack_d), sys_wraddr += BURST, go IDLE.
//  If the sum == FRAME_WORDS: sys_wraddr<=0 and wr_frame_done pulses that same cycle.
// RD_REQ / RD_BUSY: same rules using sdram_rd_ack, sys_rdaddr and rd_frame_done.
// Addresses are stable from req assertion through ack fall; they change only on the ack falling-edge cycle.
// Minimum gap between bursts: 1 cycle in IDLE. req is never raised while any ack is high.
// An ack arriving outside its matching REQ/BUSY state is ignored; no state or address change.
// rd_enable deasserted mid-burst: the burst completes normally; takes effect only in IDLE.
// Address arithmetic is ADDR_W-bit unsigned; compare before wrap, no overflow past FRAME_WORDS.
// rst_n asserted mid-burst: immediate return to reset values. Controller reset shares rst_n.
// TESTING
// 1. init_done=0, wrfifo_usedw=300 -> no req for 1000 cycles. init_done=1 -> wr_req high next cycle, addr 0.
// 2. Write burst: ack high for 256 cycles -> req drops on ack rise+1. sys_wraddr=256 after ack fall. Back to IDLE.
// 3. wr_ok & rd_ok both held -> grants alternate W,R,W,R. Read addresses advance 0,256,512.
// 4. FRAME_WORDS=1024 -> after the 4th write burst sys_wraddr=0 and exactly one wr_frame_done pulse.
// 5. Ack delayed 40 cycles (refresh) -> req stays high, address is stable, no duplicate request.
// 6. rst_n pulsed low during WR_BUSY -> all outputs return to reset values. Next grant restarts at address 0.

Source files
------------

// File: rtl/sdram_req_arbiter.sv
// Request initiator for the SDRAM controller: arbitrates write/read bursts from FIFO
// fill levels, holds one request outstanding at a time and walks wrapping frame addresses.
module sdram_req_arbiter #(
  parameter logic [8:0]        BURST       = 9'd256,
  parameter int                ADDR_W      = 22,
  parameter logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(384000),
  parameter logic [8:0]        WR_THRESH   = 9'd256,
  parameter logic [8:0]        RD_THRESH   = 9'd256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic              rd_enable,
  input  logic [8:0]        wrfifo_usedw,
  input  logic [8:0]        rdfifo_usedw,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [8:0]        sdwr_byte,
  output logic [8:0]        sdrd_byte,
  output logic [ADDR_W-1:0] sys_wraddr,
  output logic [ADDR_W-1:0] sys_rdaddr,
  output logic              wr_frame_done,
  output logic              rd_frame_done,
  output logic [2:0]        state_dbg
);

  // Handshake: req rises from IDLE only while both acks are low and stays high until
  // the matching ack rises; the burst ends on that ack's falling edge.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_BUSY = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_BUSY = 3'd4;

  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST);

  logic [2:0]        state;
  logic              wr_ack_d;
  logic              rd_ack_d;
  logic              last_grant_rd;
  logic              wr_ok;
  logic              rd_ok;
  logic              grant_wr;
  logic              grant_rd;
  logic              wr_rise;
  logic              wr_fall;
  logic              rd_rise;
  logic              rd_fall;
  logic [ADDR_W-1:0] wr_next;
  logic [ADDR_W-1:0] rd_next;
  logic              wr_wrap;
  logic              rd_wrap;

  assign sdwr_byte = BURST;
  assign sdrd_byte = BURST;
  assign state_dbg = state;

  always_comb begin
    wr_ok    = wrfifo_usedw >= WR_THRESH;
    rd_ok    = rd_enable && (rdfifo_usedw < RD_THRESH);
    // Round-robin when both are ready: the side not granted last time wins.
    grant_wr = wr_ok && (!rd_ok || last_grant_rd);
    grant_rd = rd_ok && (!wr_ok || !last_grant_rd);
    wr_rise  = sdram_wr_ack && !wr_ack_d;
    wr_fall  = !sdram_wr_ack && wr_ack_d;
    rd_rise  = sdram_rd_ack && !rd_ack_d;
    rd_fall  = !sdram_rd_ack && rd_ack_d;
    wr_next  = sys_wraddr + BURST_A;
    rd_next  = sys_rdaddr + BURST_A;
    wr_wrap  = wr_next == FRAME_WORDS;
    rd_wrap  = rd_next == FRAME_WORDS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ack_d      <= 1'b0;
      rd_ack_d      <= 1'b0;
      last_grant_rd <= 1'b1;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sys_wraddr    <= '0;
      sys_rdaddr    <= '0;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
    end else begin
      wr_ack_d      <= sdram_wr_ack;
      rd_ack_d      <= sdram_rd_ack;
      wr_frame_done <= 1'b0;
      rd_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sdram_init_done && !sdram_wr_ack && !sdram_rd_ack) begin
            if (grant_wr) begin
              sdram_wr_req  <= 1'b1;
              last_grant_rd <= 1'b0;
              state         <= WR_REQ;
            end else if (grant_rd) begin
              sdram_rd_req  <= 1'b1;
              last_grant_rd <= 1'b1;
              state         <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (wr_rise) begin
            sdram_wr_req <= 1'b0;
            state        <= WR_BUSY;
          end
        end
        WR_BUSY: begin
          if (wr_fall) begin
            sys_wraddr    <= wr_wrap ? '0 : wr_next;
            wr_frame_done <= wr_wrap;
            state         <= IDLE;
          end
        end
        RD_REQ: begin
          if (rd_rise) begin
            sdram_rd_req <= 1'b0;
            state        <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (rd_fall) begin
            sys_rdaddr    <= rd_wrap ? '0 : rd_next;
            rd_frame_done <= rd_wrap;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
